// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings used by the receiver, the
// transmitter and the formal harness, plus frame-size and timing defaults.
package uart_pkg;

    localparam int unsigned STATE_WIDTH = 4;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] START  = 4'd1;
    localparam logic [3:0] DATA_0 = 4'd2;
    localparam logic [3:0] DATA_1 = 4'd3;
    localparam logic [3:0] DATA_2 = 4'd4;
    localparam logic [3:0] DATA_3 = 4'd5;
    localparam logic [3:0] DATA_4 = 4'd6;
    localparam logic [3:0] DATA_5 = 4'd7;
    localparam logic [3:0] DATA_6 = 4'd8;
    localparam logic [3:0] DATA_7 = 4'd9;
    localparam logic [3:0] PARITY = 4'd10;
    localparam logic [3:0] STOP   = 4'd11;

    localparam int unsigned DEFAULT_INPUT_DATA_WIDTH           = 8;
    // start + data + parity + stop
    localparam int unsigned NUMBER_OF_BITS                     = DEFAULT_INPUT_DATA_WIDTH + 3;
    localparam int unsigned DEFAULT_CLOCKS_PER_BIT             = 8;
    localparam int unsigned DEFAULT_NUMBER_OF_RX_SYNCHRONIZERS = 3;

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Flop chain bringing the asynchronous serial line into the clk domain.
// All stages reset to 1 so an idle (high) line never looks like a start edge.
// Ports:
//   clk     - clock
//   reset   - asynchronous active-low reset
//   async_i - asynchronous input
//   sync_o  - synchronized output (last stage of the chain)
module uart_rx_synchronizer #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [DEPTH-1:0] chain_q;
    logic [DEPTH-1:0] chain_d;

    // Shift form works for any depth, including a single stage.
    always_comb begin
        chain_d = (chain_q << 1) | DEPTH'(async_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_o = chain_q[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, INPUT_DATA_WIDTH data bits LSB-first, 1 parity
// bit, 1 stop bit. Each bit is sampled at mid-bit using a per-state counter.
// Ports:
//   clk            - sole clock
//   reset          - asynchronous active-low reset
//   serial_in      - asynchronous serial line, idles high
//   received_data  - payload of the last good frame
//   data_is_valid  - one-cycle pulse on a good stop bit
//   rx_error       - parity mismatch, only ever high with data_is_valid
//   framing_error  - one-cycle pulse when the stop bit is sampled low
//   busy           - high whenever the FSM is not idle
//   state          - current FSM state
import uart_pkg::*;

module uart_rx #(
    parameter int unsigned INPUT_DATA_WIDTH           = DEFAULT_INPUT_DATA_WIDTH,
    parameter int unsigned CLOCKS_PER_BIT             = DEFAULT_CLOCKS_PER_BIT,
    parameter int unsigned NUMBER_OF_RX_SYNCHRONIZERS = DEFAULT_NUMBER_OF_RX_SYNCHRONIZERS,
    parameter int unsigned PARITY_ODD                 = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        framing_error,
    output logic                        busy,
    output logic [3:0]                  state
);

    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [3:0] LAST_DATA = DATA_0 + 4'(INPUT_DATA_WIDTH - 1);

    logic                        sync_rx;
    // Previous value of sync_rx, for falling-edge detection.
    logic                        sync_rx_prev_q;
    logic [3:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                        perr_q, perr_d;
    logic [INPUT_DATA_WIDTH-1:0] received_data_q, received_data_d;
    logic                        data_valid_q, data_valid_d;
    logic                        rx_error_q, rx_error_d;
    logic                        framing_error_q, framing_error_d;

    uart_rx_synchronizer #(
        .DEPTH (NUMBER_OF_RX_SYNCHRONIZERS)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (serial_in),
        .sync_o  (sync_rx)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + CNT_W'(1);
        shift_d         = shift_q;
        perr_d          = perr_q;
        received_data_d = received_data_q;
        data_valid_d    = 1'b0;
        rx_error_d      = 1'b0;
        framing_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge, not level: a line stuck low cannot retrigger.
                if (!sync_rx && sync_rx_prev_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sync_rx ? IDLE : DATA_0;
                end
            end
            PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    perr_d  = (^shift_q) ^ sync_rx ^ PARITY_ODD[0];
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync_rx) begin
                        received_data_d = shift_q;
                        data_valid_d    = 1'b1;
                        rx_error_d      = perr_q;
                    end else begin
                        framing_error_d = 1'b1;
                    end
                end
            end
            default: begin
                if (state_q >= DATA_0 && state_q <= LAST_DATA) begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d = '0;
                        // LSB arrives first, so after the last shift it sits at bit 0.
                        shift_d = {sync_rx, shift_q[INPUT_DATA_WIDTH-1:1]};
                        state_d = (state_q == LAST_DATA) ? PARITY : state_q + 4'd1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_rx_prev_q  <= 1'b1;
            state_q         <= IDLE;
            cnt_q           <= '0;
            shift_q         <= '0;
            perr_q          <= 1'b0;
            received_data_q <= '0;
            data_valid_q    <= 1'b0;
            rx_error_q      <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            sync_rx_prev_q  <= sync_rx;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            shift_q         <= shift_d;
            perr_q          <= perr_d;
            received_data_q <= received_data_d;
            data_valid_q    <= data_valid_d;
            rx_error_q      <= rx_error_d;
            framing_error_q <= framing_error_d;
        end
    end

    assign received_data = received_data_q;
    assign data_is_valid = data_valid_q;
    assign rx_error      = rx_error_q;
    assign framing_error = framing_error_q;
    assign busy          = (state_q != IDLE);
    assign state         = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit-serially, expected
// results are queued at drive time and popped when the receiver pulses.
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int PULSE_LAT = 88;  // drive of start bit -> result pulse
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_DATA_4 = 4'd6;
    localparam logic [3:0] ST_STOP   = 4'd11;

    typedef struct {
        bit         framing;
        logic [7:0] data;
        bit         err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] received_data;
    logic       data_is_valid;
    logic       rx_error;
    logic       framing_error;
    logic       busy;
    logic [3:0] state;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx #(
        .INPUT_DATA_WIDTH           (8),
        .CLOCKS_PER_BIT             (CPB),
        .NUMBER_OF_RX_SYNCHRONIZERS (3),
        .PARITY_ODD                 (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .received_data (received_data),
        .data_is_valid (data_is_valid),
        .rx_error      (rx_error),
        .framing_error (framing_error),
        .busy          (busy),
        .state         (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset) begin
            vectors++;
            if (rx_error && !data_is_valid) begin
                miscompares++;
                $display("FAIL rx_error_qualified cyc=%0d rx_error=%0b valid=%0b, required rx_error=0",
                         cyc, rx_error, data_is_valid);
            end
            if (data_is_valid || framing_error) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse cyc=%0d valid=%0b framing=%0b, required none",
                             cyc, data_is_valid, framing_error);
                end else begin
                    mon_e = sb.pop_front();
                    if (data_is_valid !== !mon_e.framing || framing_error !== mon_e.framing ||
                        cyc != mon_e.cyc ||
                        (!mon_e.framing && (received_data !== mon_e.data ||
                                            rx_error !== mon_e.err))) begin
                        miscompares++;
                        $display("FAIL frame_result got valid=%0b framing=%0b data=%02h err=%0b cyc=%0d, required valid=%0b framing=%0b data=%02h err=%0b cyc=%0d",
                                 data_is_valid, framing_error, received_data, rx_error, cyc,
                                 !mon_e.framing, mon_e.framing, mon_e.data, mon_e.err, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit flip_par,
                                               input bit stop);
        return {stop, (^d) ^ flip_par, d, 1'b0};
    endfunction

    task automatic drive_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            serial_in = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_good(input logic [7:0] d, input bit flip_par);
        exp_t e;
        e.framing = 1'b0;
        e.data    = d;
        e.err     = flip_par;
        e.cyc     = cyc + PULSE_LAT;
        sb.push_back(e);
        drive_bits(make_frame(d, flip_par, 1'b1), 11);
    endtask

    task automatic wait_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        ok = (sb.size() == 0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (received_data !== 8'h00 || data_is_valid !== 1'b0 || rx_error !== 1'b0 ||
            framing_error !== 1'b0 || busy !== 1'b0 || state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_values got data=%02h v=%0b e=%0b f=%0b busy=%0b st=%0d, required all 0",
                     received_data, data_is_valid, rx_error, framing_error, busy, state);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (state !== ST_IDLE || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got st=%0d busy=%0b, required st=0 busy=0", state, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame;
        int c0;
        bit ok;
        c0 = cyc;
        fork
            send_good(8'hA5, 1'b0);
            begin
                wait_cyc(c0 + 3);
                vectors++;
                if (state !== ST_IDLE || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL t0_idle got st=%0d busy=%0b, required st=0 busy=0", state, busy);
                end
                wait_cyc(c0 + 4);
                vectors++;
                if (state !== ST_START || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL start_entry got st=%0d busy=%0b, required st=1 busy=1", state, busy);
                end
                wait_cyc(c0 + 87);
                vectors++;
                if (state !== ST_STOP || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stop_sample_busy got st=%0d busy=%0b, required st=11 busy=1",
                             state, busy);
                end
                wait_cyc(c0 + 88);
                vectors++;
                if (state !== ST_IDLE || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_with_pulse got st=%0d busy=%0b, required st=0 busy=0",
                             state, busy);
                end
            end
        join
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL good_frame_drain got pending result, required pulse for A5");
        end
    endtask

    task automatic test_parity_error;
        bit ok;
        send_good(8'h3C, 1'b1);
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL parity_drain got pending result, required pulse for 3C");
        end
    endtask

    task automatic test_glitch;
        int c0;
        c0 = cyc;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        serial_in = 1'b1;
        wait_cyc(c0 + 4);
        vectors++;
        if (state !== ST_START) begin
            miscompares++;
            $display("FAIL glitch_start got st=%0d, required st=1", state);
        end
        wait_cyc(c0 + 8);
        vectors++;
        if (state !== ST_IDLE || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_return got st=%0d busy=%0b, required st=0 busy=0", state, busy);
        end
        repeat (100) @(negedge clk);
        vectors++;
        if (state !== ST_IDLE || received_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL glitch_quiet got st=%0d data=%02h, required st=0 data=3C",
                     state, received_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_framing;
        int  c0;
        int  bad;
        bit  ok;
        exp_t e;
        c0 = cyc;
        bad = 0;
        e.framing = 1'b1;
        e.data    = 8'h81;
        e.err     = 1'b0;
        e.cyc     = c0 + PULSE_LAT;
        sb.push_back(e);
        fork
            begin
                drive_bits(make_frame(8'h81, 1'b0, 1'b0), 11);
                repeat (40) @(posedge clk);
                #1;
                serial_in = 1'b1;
            end
            begin
                wait_cyc(c0 + 88);
                vectors++;
                if (state !== ST_IDLE || framing_error !== 1'b1 || data_is_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL framing_pulse got st=%0d f=%0b v=%0b, required st=0 f=1 v=0",
                             state, framing_error, data_is_valid);
                end
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (state !== ST_IDLE || busy !== 1'b0) bad++;
                end
                vectors++;
                if (bad != 0) begin
                    miscompares++;
                    $display("FAIL low_line_idle got %0d non-idle cycles, required 0", bad);
                end
            end
        join
        wait_drain(ok);
        vectors++;
        if (!ok || received_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL framing_hold got drained=%0b data=%02h, required drained=1 data=3C",
                     ok, received_data);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        bit ok;
        send_good(8'h00, 1'b0);
        send_good(8'hFF, 1'b0);
        wait_drain(ok);
        vectors++;
        if (!ok || received_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL back_to_back got drained=%0b data=%02h, required drained=1 data=FF",
                     ok, received_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        drive_bits(make_frame(8'h55, 1'b0, 1'b1), 5);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (state !== ST_DATA_4) begin
            miscompares++;
            $display("FAIL mid_frame_state got st=%0d, required st=6", state);
        end
        reset = 1'b0;
        serial_in = 1'b1;
        #1;
        vectors++;
        if (received_data !== 8'h00 || data_is_valid !== 1'b0 || rx_error !== 1'b0 ||
            framing_error !== 1'b0 || busy !== 1'b0 || state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL async_reset got data=%02h v=%0b e=%0b f=%0b busy=%0b st=%0d, required all 0",
                     received_data, data_is_valid, rx_error, framing_error, busy, state);
        end
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (state !== ST_IDLE || busy !== 1'b0 || received_data !== 8'h00) begin
            miscompares++;
            $display("FAIL post_reset_idle got st=%0d busy=%0b data=%02h, required 0 0 00",
                     state, busy, received_data);
        end
        @(posedge clk);
        #1;
        send_good(8'h3C, 1'b0);
        wait_drain(ok);
        vectors++;
        if (!ok || received_data !== 8'h3C || rx_error !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_frame got drained=%0b data=%02h err=%0b, required 1 3C 0",
                     ok, received_data, rx_error);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
